// File: rtl/video_pkg.sv
// Shared types and constants for the video test-pattern writer.
package video_pkg;

    typedef enum logic {
        StWrite   = 1'b0,
        StRelease = 1'b1
    } mire_state_e;

    localparam logic [23:0] ColorWhite = 24'hFFFFFF;
    localparam logic [23:0] ColorBlack = 24'h000000;
    localparam logic [3:0]  GridMask   = 4'hF;

endpackage

// File: rtl/wshb_if.sv
// Wishbone classic bus bundle between a write master and the SDRAM controller.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic        ack;

    modport master (
        input  clk, rst, ack,
        output cyc, stb, we, sel, cti, bte, adr, dat_ms
    );

    modport slave (
        input  clk, rst, cyc, stb, we, sel, cti, bte, adr, dat_ms,
        output ack
    );
endinterface

// File: rtl/mire_pattern.sv
// Grid test-pattern colour: white on every 16th column/row, black elsewhere.
module mire_pattern
    import video_pkg::*;
#(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 9
) (
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    output logic [23:0]   o_rgb
);
    logic w_x_hit;
    logic w_y_hit;

    // Zero-extend so narrow coordinates (fewer than 4 bits) still compare correctly.
    assign w_x_hit = ((32'(i_x) & 32'(GridMask)) == 32'd0);
    assign w_y_hit = ((32'(i_y) & 32'(GridMask)) == 32'd0);
    assign o_rgb   = (w_x_hit || w_y_hit) ? ColorWhite : ColorBlack;

endmodule

// File: rtl/mire.sv
// Test-pattern generator writing an HDISP x VDISP grid into the framebuffer over
// Wishbone, releasing the bus every NWRITE writes.
module mire
    import video_pkg::*;
#(
    parameter int unsigned HDISP  = 800,
    parameter int unsigned VDISP  = 480,
    parameter int unsigned NWRITE = 64
) (
    wshb_if.master wshb_ifm,
    output logic   frame_done
);
    localparam int unsigned XW = $clog2(HDISP);
    localparam int unsigned YW = $clog2(VDISP);
    localparam int unsigned CW = $clog2(NWRITE + 1);

    mire_state_e   r_state;
    mire_state_e   w_state_next;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_adr;
    logic          r_frame_done;

    logic [23:0]   w_rgb;
    logic          w_ack;
    logic          w_x_last;
    logic          w_y_last;
    logic          w_frame_end;
    logic          w_tenure_end;

    // Acks seen while the bus is released do not belong to any write.
    assign w_ack        = wshb_ifm.ack && (r_state == StWrite);
    assign w_x_last     = (r_x == XW'(HDISP - 1));
    assign w_y_last     = (r_y == YW'(VDISP - 1));
    assign w_frame_end  = w_ack && w_x_last && w_y_last;
    assign w_tenure_end = w_ack && (r_cnt == CW'(NWRITE - 1));

    mire_pattern #(
        .XW (XW),
        .YW (YW)
    ) u_pattern (
        .i_x   (r_x),
        .i_y   (r_y),
        .o_rgb (w_rgb)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StWrite:   if (w_tenure_end) w_state_next = StRelease;
            StRelease: w_state_next = StWrite;
            default:   w_state_next = StWrite;
        endcase
    end

    always_ff @(posedge wshb_ifm.clk or posedge wshb_ifm.rst) begin
        if (wshb_ifm.rst) begin
            r_state      <= StWrite;
            r_x          <= '0;
            r_y          <= '0;
            r_cnt        <= '0;
            r_adr        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= w_frame_end;
            if (w_ack) begin
                r_adr <= w_frame_end ? 32'd0 : r_adr + 32'd4;
                r_cnt <= w_tenure_end ? '0 : r_cnt + 1'b1;
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    assign wshb_ifm.cyc    = (r_state == StWrite);
    assign wshb_ifm.stb    = (r_state == StWrite);
    assign wshb_ifm.we     = 1'b1;
    assign wshb_ifm.sel    = 4'b1111;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;
    assign wshb_ifm.adr    = r_adr;
    assign wshb_ifm.dat_ms = {8'h00, w_rgb};
    assign frame_done      = r_frame_done;

endmodule

// File: tb/tb_mire.sv
// Scoreboard bench for mire: two instances (full-size and a tiny frame whose end
// coincides with the bus release), checked every cycle against a pixel-index model.
module tb_mire;

    localparam int unsigned HA = 800, VA = 480, NA = 64;
    localparam int unsigned HB = 32,  VB = 4,   NB = 128;
    localparam int NCYC = 2200;

    typedef struct {
        logic        cyc;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic fd_a;
    logic fd_b;

    always #5 clk = ~clk;

    wshb_if wb_a (.clk(clk), .rst(rst_a));
    wshb_if wb_b (.clk(clk), .rst(rst_b));

    mire #(.HDISP(HA), .VDISP(VA), .NWRITE(NA)) dut_a (
        .wshb_ifm   (wb_a),
        .frame_done (fd_a)
    );

    mire #(.HDISP(HB), .VDISP(VB), .NWRITE(NB)) dut_b (
        .wshb_ifm   (wb_b),
        .frame_done (fd_b)
    );

    // Reference model: pixel index, writes in current tenure, idle cycle flag.
    int unsigned m_pix [2];
    int unsigned m_cnt [2];
    bit          m_idle[2];
    bit          m_fd  [2];

    exp_t q_a[$];
    exp_t q_b[$];

    int  total = 0;
    int  bad = 0;
    int  fd_seen = 0;
    int  fd_exp_cnt = 0;
    bit  stim_done = 1'b0;

    function automatic logic [23:0] pix_rgb(input int unsigned pix, input int unsigned h);
        int unsigned x = pix % h;
        int unsigned y = pix / h;
        return ((x % 16 == 0) || (y % 16 == 0)) ? 24'hFFFFFF : 24'h000000;
    endfunction

    task automatic model_reset(input int k);
        m_pix[k]  = 0;
        m_cnt[k]  = 0;
        m_idle[k] = 1'b0;
        m_fd[k]   = 1'b0;
    endtask

    task automatic model_advance(input int k, input int unsigned h, input int unsigned v,
                                 input int unsigned n, input bit ack, input bit rst_at_edge);
        m_fd[k] = 1'b0;
        if (!rst_at_edge) begin
            if (m_idle[k]) begin
                m_idle[k] = 1'b0;
            end else if (ack) begin
                m_pix[k] = m_pix[k] + 1;
                if (m_pix[k] == h * v) begin
                    m_pix[k] = 0;
                    m_fd[k]  = 1'b1;
                end
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == n) begin
                    m_cnt[k]  = 0;
                    m_idle[k] = 1'b1;
                end
            end
        end
    endtask

    function automatic exp_t make_exp(input int k, input int unsigned h);
        exp_t e;
        e.cyc = !m_idle[k];
        e.adr = 32'(4 * m_pix[k]);
        e.dat = {8'h00, pix_rgb(m_pix[k], h)};
        e.fd  = m_fd[k];
        return e;
    endfunction

    task automatic check(input string nm, input exp_t e, input logic cyc, input logic stb,
                         input logic we, input logic [3:0] sel, input logic [2:0] cti,
                         input logic [1:0] bte, input logic [31:0] adr,
                         input logic [31:0] dat, input logic fd);
        total++;
        if (cyc !== e.cyc || stb !== e.cyc || we !== 1'b1 || sel !== 4'hF || cti !== 3'd0 ||
            bte !== 2'd0 || adr !== e.adr || dat !== e.dat || fd !== e.fd) begin
            bad++;
            $display("FAIL %s t=%0t got cyc=%b stb=%b we=%b sel=%h cti=%h bte=%h adr=%h dat=%h fd=%b exp cyc=stb=%b adr=%h dat=%h fd=%b",
                     nm, $time, cyc, stb, we, sel, cti, bte, adr, dat, fd,
                     e.cyc, e.adr, e.dat, e.fd);
        end
    endtask

    // Stimulus: drive 1 time unit after each rising edge, push the expected cycle view.
    initial begin
        bit ack_prev[2];
        bit rst_prev[2];
        bit rst_now;
        bit ack_now;
        bit pulsed_a = 1'b0;
        ack_prev = '{1'b0, 1'b0};
        rst_prev = '{1'b1, 1'b1};
        rst_a = 1'b1;
        rst_b = 1'b1;
        wb_a.ack = 1'b0;
        wb_b.ack = 1'b0;
        model_reset(0);
        model_reset(1);
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            model_advance(0, HA, VA, NA, ack_prev[0], rst_prev[0]);
            rst_now = (c < 3);
            if (!pulsed_a && c >= 3 && !m_idle[0] && m_pix[0] == 100) begin
                rst_now  = 1'b1;
                pulsed_a = 1'b1;
            end
            if (rst_now) model_reset(0);
            rst_a = rst_now;
            q_a.push_back(make_exp(0, HA));
            if (c < 3)         ack_now = 1'b0;
            else if (c < 400)  ack_now = 1'b1;
            else if (c < 1100) ack_now = (c % 3 == 0);
            else               ack_now = 1'($urandom_range(0, 1));
            wb_a.ack    = ack_now;
            ack_prev[0] = ack_now;
            rst_prev[0] = rst_now;

            model_advance(1, HB, VB, NB, ack_prev[1], rst_prev[1]);
            rst_now = (c < 2) || (c == 1500);
            if (rst_now) model_reset(1);
            rst_b = rst_now;
            if (m_fd[1]) fd_exp_cnt++;
            q_b.push_back(make_exp(1, HB));
            if (c < 600) ack_now = 1'b1;
            else         ack_now = ($urandom_range(0, 3) != 0);
            wb_b.ack    = ack_now;
            ack_prev[1] = ack_now;
            rst_prev[1] = rst_now;
        end
        stim_done = 1'b1;
    end

    // Monitor: compare the DUT view against the queued expectation mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() != 0) begin
            e = q_a.pop_front();
            check("mire_a", e, wb_a.cyc, wb_a.stb, wb_a.we, wb_a.sel, wb_a.cti, wb_a.bte,
                  wb_a.adr, wb_a.dat_ms, fd_a);
        end
        if (q_b.size() != 0) begin
            e = q_b.pop_front();
            check("mire_b", e, wb_b.cyc, wb_b.stb, wb_b.we, wb_b.sel, wb_b.cti, wb_b.bte,
                  wb_b.adr, wb_b.dat_ms, fd_b);
            if (fd_b) fd_seen++;
        end
        if (stim_done && q_a.size() == 0 && q_b.size() == 0) begin
            total++;
            if (fd_seen != fd_exp_cnt || fd_exp_cnt == 0) begin
                bad++;
                $display("FAIL frame_count got=%0d exp=%0d", fd_seen, fd_exp_cnt);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

endmodule
